// File: rtl/presence_detector.sv
// presence_detector: HC-SR04 ranging loop with debounced near/far presence flag.
// Fires a trigger pulse every PERIOD_CYCLES, measures the synchronised echo
// width (saturating at MAX_ECHO_CYCLES) and toggles presence after CONFIRM_N
// consecutive measurements that contradict the current state.
// Optional build macro PRESENCE_HYST_EN: release threshold becomes
// NEAR_CYCLES + HYST_CYCLES instead of NEAR_CYCLES.
module presence_detector #(
  parameter int unsigned PERIOD_CYCLES   = 3_000_000,
  parameter int unsigned TRIG_CYCLES     = 500,
  parameter int unsigned MAX_ECHO_CYCLES = 1_500_000,
  parameter int unsigned NEAR_CYCLES     = 29_000,
  parameter int unsigned HYST_CYCLES     = 5_800,
  parameter int unsigned CONFIRM_N       = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        echo,
  output logic        trig,
  output logic        presence,
  output logic [20:0] meas_cycles,
  output logic        meas_valid
);

  localparam int unsigned PW = $clog2(PERIOD_CYCLES);
  localparam int unsigned TW = $clog2(TRIG_CYCLES + 1);
  localparam int unsigned AW = $clog2(CONFIRM_N + 1);

`ifdef PRESENCE_HYST_EN
  localparam bit HYST_ON = 1'b1;
`else
  localparam bit HYST_ON = 1'b0;
`endif

  localparam logic [PW-1:0] PER_LAST  = PW'(PERIOD_CYCLES - 1);
  localparam logic [TW-1:0] TRIG_LAST = TW'(TRIG_CYCLES - 1);
  localparam logic [AW-1:0] CONF_LAST = AW'(CONFIRM_N - 1);
  localparam logic [20:0]   MAX_W     = 21'(MAX_ECHO_CYCLES);
  localparam logic [20:0]   MAX_LAST  = 21'(MAX_ECHO_CYCLES - 1);
  localparam logic [20:0]   NEAR_TH   = 21'(NEAR_CYCLES);
  localparam logic [20:0]   FAR_TH    = 21'(NEAR_CYCLES + (HYST_ON ? HYST_CYCLES : 32'd0));

  localparam logic [2:0] S_TRIG    = 3'd0;
  localparam logic [2:0] S_WAIT_HI = 3'd1;
  localparam logic [2:0] S_MEASURE = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
  localparam logic [2:0] S_GAP     = 3'd4;

  logic [2:0]    state, state_nxt;
  logic          run;
  logic [PW-1:0] period_cnt;
  logic [TW-1:0] trig_cnt;
  logic [20:0]   width_cnt;
  logic [AW-1:0] agree_cnt;
  logic          stuck;
  logic          echo_meta, echo_sync, echo_prev;

  logic          rise;
  logic          finish;
  logic [20:0]   result;
  logic          is_near, is_far, contra, agree;

  // run stays low for the first cycle after reset so TRIG begins with clean
  // counters and trig is held low for every cycle that rst is sampled high
  assign trig = run & (state == S_TRIG);
  assign rise = echo_sync & ~echo_prev;

  // two-flop synchroniser plus edge-detect history for the echo line
  always_ff @(posedge clk) begin
    if (rst) begin
      echo_meta <= 1'b0;
      echo_sync <= 1'b0;
      echo_prev <= 1'b0;
    end else begin
      echo_meta <= echo;
      echo_sync <= echo_meta;
      echo_prev <= echo_sync;
    end
  end

  // next-state decode and measurement result selection
  always_comb begin
    state_nxt = state;
    finish    = 1'b0;
    result    = '0;
    case (state)
      S_TRIG: begin
        if (trig_cnt == TRIG_LAST) state_nxt = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (stuck) begin
          finish    = 1'b1;
          result    = MAX_W;
          state_nxt = S_DONE;
        end else if (rise) begin
          state_nxt = S_MEASURE;
        end else if (width_cnt == MAX_LAST) begin
          finish    = 1'b1;
          result    = MAX_W;
          state_nxt = S_DONE;
        end
      end
      S_MEASURE: begin
        if (!echo_sync) begin
          finish    = 1'b1;
          result    = width_cnt;
          state_nxt = S_DONE;
        end else if (width_cnt >= MAX_LAST) begin
          finish    = 1'b1;
          result    = MAX_W;
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_GAP;
      S_GAP: begin
        if (period_cnt == PER_LAST) state_nxt = S_TRIG;
      end
      default: state_nxt = S_TRIG;
    endcase
  end

  // near/far classification of the result about to be published
  always_comb begin
    is_near = (result < NEAR_TH);
    is_far  = (result >= FAR_TH);
    contra  = presence ? is_far  : is_near;
    agree   = presence ? is_near : is_far;
  end

  // FSM, counters, published measurement and debounced presence
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_TRIG;
      run         <= 1'b0;
      period_cnt  <= '0;
      trig_cnt    <= '0;
      width_cnt   <= '0;
      agree_cnt   <= '0;
      stuck       <= 1'b0;
      presence    <= 1'b0;
      meas_cycles <= '0;
      meas_valid  <= 1'b0;
    end else if (!run) begin
      run <= 1'b1;
    end else begin
      state      <= state_nxt;
      meas_valid <= finish;
      // period restarts exactly on the GAP->TRIG transition
      period_cnt <= (state == S_GAP && state_nxt == S_TRIG) ? '0 : period_cnt + 1'b1;

      if (state == S_TRIG) begin
        trig_cnt  <= (trig_cnt == TRIG_LAST) ? '0 : trig_cnt + 1'b1;
        width_cnt <= '0;
        // an echo already high when the trigger starts cannot be trusted
        if (trig_cnt == '0) stuck <= echo_sync;
      end else begin
        trig_cnt <= '0;
        if (state == S_WAIT_HI) width_cnt <= rise ? 21'd1 : width_cnt + 21'd1;
        else if (state == S_MEASURE) width_cnt <= width_cnt + 21'd1;
      end

      if (finish) begin
        meas_cycles <= result;
        if (contra) begin
          if (agree_cnt == CONF_LAST) begin
            presence  <= ~presence;
            agree_cnt <= '0;
          end else begin
            agree_cnt <= agree_cnt + 1'b1;
          end
        end else if (agree) begin
          agree_cnt <= '0;
        end
      end
    end
  end

endmodule
